fault_task_scheduler: RTL and testbench
=======================================

Name: fault_task_scheduler

Overview:
- Buffers fault-unit reports and sequences the bot's three-phase service loop for each one: IDENTIFY_FAULT, PICK_BLOCK, BLOCK_DROP.
- For each phase it issues one endpoint request (cpu_en + ep) to the path-planner CPU and waits for move completion.
- Sits between the message decoder (unit_msg/unit_pulse), the pick-block module (pbm_complete/su) and the path planner.

Parameters:
- DEPTH, 4, fault-unit FIFO entries (power of 2, >=2)
- EP_W, 5, endpoint node width
- EP_U0, 29, endpoint node for unit/supply code 00
- EP_U1, 8, endpoint node for code 01
- EP_U2, 19, endpoint node for code 10
- EP_U3, 19, endpoint node for supply code 11

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- unit_msg  in  1  one-cycle strobe: unit_pulse is valid
- unit_pulse  in  2  faulty unit code (00/01/10 valid; 11 invalid)
- pbm_complete  in  1  level: pick-block module has resolved supply unit
- su  in  2  supply unit code, valid while pbm_complete=1
- req_ready  in  1  planner accepts the current request this cycle
- move_done  in  1  one-cycle pulse: bot reached the last requested endpoint
- cpu_en  out  1  request valid to planner
- ep  out  EP_W  requested endpoint node
- i_fault  out  1  high during IDENTIFY and DROP phases
- phase  out  2  00 idle, 01 identify, 10 pick, 11 drop
- busy  out  1  a task is in progress (FSM not IDLE)
- fifo_count  out  $clog2(DEPTH)+1  entries queued
- overflow  out  1  sticky: report lost because FIFO was full
- bad_unit  out  1  sticky: unit_msg arrived with code 11

Behaviour:
- Reset (rst=1 at a clk edge, including mid-task): FSM goes to IDLE and the FIFO empties. All outputs are 0: cpu_en, ep, i_fault, phase, busy, fifo_count, overflow, bad_unit. An in-flight request is abandoned.
- All logic is synchronous to clk.
- Code-to-endpoint mapping: 00->EP_U0, 01->EP_U1, 10->EP_U2, 11->EP_U3. Code 11 is used only for su.
- FIFO push:
  - On unit_msg=1 with unit_pulse!=11.
  - If unit_pulse=11, the entry is dropped and bad_unit is set.
  - If the FIFO is full and no pop occurs in the same cycle, the entry is dropped and overflow is set.
  - Simultaneous push and pop while full is accepted.
- FIFO pop: occurs on the IDLE->ID_REQ transition. The popped code is latched into cur_unit for the whole task.
- States and transitions:
  - IDLE: if fifo_count>0, pop and go to ID_REQ. An entry pushed in cycle N is popped no earlier than N+1.
  - ID_REQ: cpu_en=1, ep=map(cur_unit). If req_ready, go to ID_WAIT.
  - ID_WAIT: on move_done, go to PB_HOLD.
  - PB_HOLD: wait for pbm_complete=1. In that cycle, latch su into cur_su and go to PB_REQ.
  - PB_REQ: cpu_en=1, ep=map(cur_su). If req_ready, go to PB_WAIT.
  - PB_WAIT: on move_done, go to BD_REQ.
  - BD_REQ: cpu_en=1, ep=map(cur_unit). If req_ready, go to BD_WAIT.
  - BD_WAIT: on move_done, go to IDLE. The task is complete; the next entry can pop in the following cycle.
- Handshake rules:
  - cpu_en and ep are registered outputs, asserted in the first cycle of each *_REQ state.
  - They are held stable until the cycle req_ready=1, and deassert in the next cycle.
  - Exactly one accepted request per phase.
  - req_ready while cpu_en=0 is ignored.
  - move_done outside *_WAIT states is ignored. This includes move_done in the same cycle as acceptance.
- Status outputs:
  - ep reads 0 when cpu_en=0.
  - i_fault=1 in ID_* and BD_* states.
  - phase follows the state group.
  - busy = (state != IDLE).
- Sticky flags clear only on rst.
- FIFO pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.

Test Plan:
- Reset mid-task: assert rst while in PB_WAIT -> next cycle all outputs 0, state IDLE, fifo_count=0; a later move_done is ignored.
- Single task: unit_pulse=01, su=10, req_ready tied 1, move_done pulsed after each request -> cpu_en pulses with ep=8, then 19, then 8. i_fault is 1,0,1 across the phases and phase is 01,10,11. busy falls after the third move_done.
- Backpressure: hold req_ready=0 for 5 cycles in ID_REQ (unit 00) -> cpu_en=1 and ep=29 are stable for all 5 cycles; exactly one request is accepted; cpu_en drops the cycle after req_ready=1.
- Queueing/overflow with DEPTH=4: push 00,01,10,00,01 with no pop -> fifo_count=4 and overflow=1. Tasks then run in order 29,8,19,29 (unit endpoints).
- Invalid code: push unit_pulse=11 -> bad_unit=1, fifo_count unchanged, no task starts.
- pbm gating: in PB_HOLD keep pbm_complete=0 for 10 cycles -> no cpu_en. Then pbm_complete=1 with su=11 -> ep=19. Changing su after that cycle does not change ep.

Source files
------------

// File: rtl/fault_task_scheduler.sv
// Fault-unit report FIFO plus the three-phase service sequencer (identify, pick, drop)
// that issues one registered endpoint request per phase to the path planner.
//
// state   | meaning
// IDLE    | no task; pops the next queued unit when one is available
// ID_REQ  | requesting the faulty unit's endpoint
// ID_WAIT | travelling to the faulty unit
// PB_HOLD | waiting for the pick-block module to resolve a supply unit
// PB_REQ  | requesting the supply unit's endpoint
// PB_WAIT | travelling to the supply unit
// BD_REQ  | requesting the faulty unit's endpoint again for the drop
// BD_WAIT | travelling back to the faulty unit
module fault_task_scheduler #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned EP_W  = 5,
  parameter int unsigned EP_U0 = 29,
  parameter int unsigned EP_U1 = 8,
  parameter int unsigned EP_U2 = 19,
  parameter int unsigned EP_U3 = 19
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     unit_msg,
  input  logic [1:0]               unit_pulse,
  input  logic                     pbm_complete,
  input  logic [1:0]               su,
  input  logic                     req_ready,
  input  logic                     move_done,
  output logic                     cpu_en,
  output logic [EP_W-1:0]          ep,
  output logic                     i_fault,
  output logic [1:0]               phase,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     bad_unit
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE, ID_REQ, ID_WAIT, PB_HOLD, PB_REQ, PB_WAIT, BD_REQ, BD_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [1:0]      unit_q, unit_d, su_q, su_d;
  logic            cpu_en_q, cpu_en_d;
  logic [EP_W-1:0] ep_q, ep_d;
  logic            overflow_q, overflow_d, bad_q, bad_d;
  logic            full, pop, push_req, push;

  function automatic logic [EP_W-1:0] ep_map(input logic [1:0] code);
    logic [EP_W-1:0] node;
    case (code)
      2'b00:   node = EP_W'(EP_U0);
      2'b01:   node = EP_W'(EP_U1);
      2'b10:   node = EP_W'(EP_U2);
      default: node = EP_W'(EP_U3);
    endcase
    return node;
  endfunction

  assign full     = (count_q == CW'(DEPTH));
  assign push_req = unit_msg && (unit_pulse != 2'b11);
  // A full FIFO still accepts a push when the same cycle pops an entry.
  assign push     = push_req && (!full || pop);

  always_comb begin
    state_d = state_q;
    unit_d  = unit_q;
    su_d    = su_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          unit_d  = mem_q[rd_ptr_q];
          state_d = ID_REQ;
        end
      end
      ID_REQ:  if (req_ready) state_d = ID_WAIT;
      ID_WAIT: if (move_done) state_d = PB_HOLD;
      PB_HOLD: begin
        if (pbm_complete) begin
          su_d    = su;
          state_d = PB_REQ;
        end
      end
      PB_REQ:  if (req_ready) state_d = PB_WAIT;
      PB_WAIT: if (move_done) state_d = BD_REQ;
      BD_REQ:  if (req_ready) state_d = BD_WAIT;
      BD_WAIT: if (move_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request outputs are registered from the next state, so they rise on entry
  // to a *_REQ state and fall the cycle after acceptance.
  always_comb begin
    cpu_en_d = 1'b0;
    ep_d     = '0;
    case (state_d)
      ID_REQ, BD_REQ: begin
        cpu_en_d = 1'b1;
        ep_d     = ep_map(unit_d);
      end
      PB_REQ: begin
        cpu_en_d = 1'b1;
        ep_d     = ep_map(su_d);
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    bad_d      = bad_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (push_req && full && !pop)            overflow_d = 1'b1;
    if (unit_msg && (unit_pulse == 2'b11))   bad_d      = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      unit_q     <= '0;
      su_q       <= '0;
      cpu_en_q   <= 1'b0;
      ep_q       <= '0;
      overflow_q <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      unit_q     <= unit_d;
      su_q       <= su_d;
      cpu_en_q   <= cpu_en_d;
      ep_q       <= ep_d;
      overflow_q <= overflow_d;
      bad_q      <= bad_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= unit_pulse;
  end

  always_comb begin
    phase = 2'b00;
    case (state_q)
      ID_REQ, ID_WAIT:          phase = 2'b01;
      PB_HOLD, PB_REQ, PB_WAIT: phase = 2'b10;
      BD_REQ, BD_WAIT:          phase = 2'b11;
      default:                  phase = 2'b00;
    endcase
  end

  assign i_fault    = phase[0];
  assign busy       = (state_q != IDLE);
  assign cpu_en     = cpu_en_q;
  assign ep         = ep_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign bad_unit   = bad_q;

endmodule

// File: tb/tb_fault_task_scheduler.sv
// Directed bench for fault_task_scheduler: expected requests are queued as stimulus
// is issued and a monitor compares each accepted planner request against the queue.
module tb_fault_task_scheduler;

  logic       clk = 1'b0;
  logic       rst, unit_msg, pbm_complete, req_ready, move_done;
  logic [1:0] unit_pulse, su;
  logic       cpu_en, i_fault, busy, overflow, bad_unit;
  logic [4:0] ep;
  logic [1:0] phase;
  logic [2:0] fifo_count;

  typedef struct {
    logic [4:0] ep;
    logic [1:0] phase;
  } req_t;

  req_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  fault_task_scheduler dut (
    .clk(clk), .rst(rst), .unit_msg(unit_msg), .unit_pulse(unit_pulse),
    .pbm_complete(pbm_complete), .su(su), .req_ready(req_ready), .move_done(move_done),
    .cpu_en(cpu_en), .ep(ep), .i_fault(i_fault), .phase(phase), .busy(busy),
    .fifo_count(fifo_count), .overflow(overflow), .bad_unit(bad_unit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted request must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && cpu_en && req_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_request_ep", int'(ep), -1);
      end else begin
        req_t e;
        e = sb.pop_front();
        chk("req_ep", int'(ep), int'(e.ep));
        chk("req_phase", int'(phase), int'(e.phase));
        chk("req_i_fault", int'(i_fault), (e.phase != 2'b10) ? 1 : 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_unit(input logic [1:0] code);
    unit_msg   = 1'b1;
    unit_pulse = code;
    tick();
    unit_msg   = 1'b0;
  endtask

  task automatic wait_en();
    int k;
    k = 0;
    while (!cpu_en && k < 50) begin
      tick();
      k++;
    end
    chk("req_timeout", int'(cpu_en), 1);
  endtask

  task automatic pulse_done();
    move_done = 1'b1;
    tick();
    move_done = 1'b0;
  endtask

  // One phase with req_ready already high: request, acceptance, then arrival.
  task automatic serve(input logic [4:0] e, input logic [1:0] ph);
    req_t r;
    r.ep    = e;
    r.phase = ph;
    sb.push_back(r);
    wait_en();
    tick();
    pulse_done();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cpu_en"}, int'(cpu_en), 0);
    chk({tag, "_ep"}, int'(ep), 0);
    chk({tag, "_i_fault"}, int'(i_fault), 0);
    chk({tag, "_phase"}, int'(phase), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_fifo_count"}, int'(fifo_count), 0);
    chk({tag, "_overflow"}, int'(overflow), 0);
    chk({tag, "_bad_unit"}, int'(bad_unit), 0);
  endtask

  logic [4:0] unit_ep [4];
  logic [1:0] order   [4];

  initial begin
    unit_ep[0] = 5'd29; unit_ep[1] = 5'd8; unit_ep[2] = 5'd19; unit_ep[3] = 5'd19;
    order[0] = 2'b00; order[1] = 2'b01; order[2] = 2'b10; order[3] = 2'b00;

    rst = 1'b1; unit_msg = 1'b0; unit_pulse = 2'b00; pbm_complete = 1'b0;
    su = 2'b00; req_ready = 1'b0; move_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk_all_zero("reset");

    // Single task: unit 01, supply 10.
    req_ready = 1'b1; pbm_complete = 1'b1; su = 2'b10;
    push_unit(2'b01);
    serve(5'd8, 2'b01);
    serve(5'd19, 2'b10);
    serve(5'd8, 2'b11);
    chk("single_busy_end", int'(busy), 0);

    // Backpressure in ID_REQ for unit 00.
    req_ready = 1'b0;
    push_unit(2'b00);
    wait_en();
    for (int i = 0; i < 5; i++) begin
      chk("bp_cpu_en", int'(cpu_en), 1);
      chk("bp_ep", int'(ep), 29);
      tick();
    end
    begin
      req_t r;
      r.ep = 5'd29; r.phase = 2'b01;
      sb.push_back(r);
    end
    req_ready = 1'b1;
    tick();
    chk("bp_cpu_en_drop", int'(cpu_en), 0);
    chk("bp_ep_drop", int'(ep), 0);
    pulse_done();
    serve(5'd19, 2'b10);
    serve(5'd29, 2'b11);

    // Queueing and overflow: hold a filler task in ID_WAIT while pushing five.
    begin
      req_t r;
      r.ep = 5'd19; r.phase = 2'b01;
      sb.push_back(r);
    end
    push_unit(2'b10);
    wait_en();
    tick();
    push_unit(2'b00);
    push_unit(2'b01);
    push_unit(2'b10);
    push_unit(2'b00);
    chk("q_count_full", int'(fifo_count), 4);
    chk("q_overflow_pre", int'(overflow), 0);
    push_unit(2'b01);
    chk("q_count_after_ovf", int'(fifo_count), 4);
    chk("q_overflow", int'(overflow), 1);
    pulse_done();
    serve(5'd19, 2'b10);
    serve(5'd19, 2'b11);
    for (int t = 0; t < 4; t++) begin
      serve(unit_ep[order[t]], 2'b01);
      serve(5'd19, 2'b10);
      serve(unit_ep[order[t]], 2'b11);
    end
    tick();
    chk("q_count_drained", int'(fifo_count), 0);
    chk("q_busy_drained", int'(busy), 0);

    // Invalid unit code.
    push_unit(2'b11);
    tick(); tick(); tick();
    chk("bad_unit_set", int'(bad_unit), 1);
    chk("bad_fifo_count", int'(fifo_count), 0);
    chk("bad_busy", int'(busy), 0);
    chk("bad_cpu_en", int'(cpu_en), 0);

    // pbm gating and su latching.
    pbm_complete = 1'b0;
    push_unit(2'b01);
    serve(5'd8, 2'b01);
    for (int i = 0; i < 10; i++) begin
      chk("pbm_hold_cpu_en", int'(cpu_en), 0);
      chk("pbm_hold_phase", int'(phase), 2);
      tick();
    end
    pbm_complete = 1'b1; su = 2'b11;
    tick();
    su = 2'b00; pbm_complete = 1'b0;
    serve(5'd19, 2'b10);
    serve(5'd8, 2'b11);

    // Reset mid-task in PB_WAIT with an entry still queued.
    pbm_complete = 1'b1; su = 2'b01;
    push_unit(2'b10);
    serve(5'd19, 2'b01);
    begin
      req_t r;
      r.ep = 5'd8; r.phase = 2'b10;
      sb.push_back(r);
    end
    wait_en();
    push_unit(2'b00);
    chk("mid_phase_pb_wait", int'(phase), 2);
    chk("mid_fifo_count", int'(fifo_count), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("midrst");
    pulse_done();
    tick(); tick();
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_cpu_en", int'(cpu_en), 0);
    chk("post_rst_phase", int'(phase), 0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
